l1_cache_control: RTL and testbench
===================================

Name: l1_cache_control

Overview:
- Control FSM and tag/status storage for the L1 cache.
- Sits directly upstream of the line-merge write logic. It drives that block's fill-select input (fill_sel → l2_read) and the per-way data-array write enables.
- Decides hit/miss, writes back dirty victims to L2, allocates lines from L2, and acknowledges the CPU.
- 2-way set-associative, write-back/write-allocate, 256-bit lines (16 words), 16-bit byte addresses.

Parameters:
- SET_BITS, 3, log2 of set count (8 sets). Tag width = 16 − 5 − SET_BITS.
- WAYS, 2, fixed associativity; only 2 is supported, and the parameter exists for assertion checks.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- mem_read  in  1  CPU read request, held until mem_resp
- mem_write  in  1  CPU write request, held until mem_resp
- mem_address  in  16  CPU byte address: tag | set | word offset[4:1] | byte[0]
- mem_resp  out  1  one-cycle CPU acknowledge
- hit_way  out  1  way whose data feeds CPU read mux / write merge
- data_we  out  2  per-way data-array write enable
- fill_sel  out  1  1 = merge source is L2 line (fill), 0 = CPU write merge
- l2_read  out  1  L2 line read request, held until l2_resp
- l2_write  out  1  L2 line writeback request, held until l2_resp
- l2_address  out  16  line address to L2, low 5 bits always 0
- wb_way  out  1  way whose data array drives L2 wdata during writeback
- l2_resp  in  1  L2 one-cycle completion

Behaviour:
- Storage (flops): valid[way][set], dirty[way][set], tag[way][set], lru[set] (lru = way to evict next).
- Reset: all valid/dirty/lru = 0, state = CHECK. All outputs are 0 the cycle after reset is sampled. Reset mid-miss abandons the L2 transaction; l2_read/l2_write drop at that edge.
- States: CHECK, WRITEBACK, ALLOCATE.
- CHECK, no request: all outputs 0.
- CHECK, request, hit (valid & tag match in way w):
  - same-cycle mem_resp=1, hit_way=w;
  - lru[set] ← ~w at the edge;
  - if write: data_we[w]=1, fill_sel=0, dirty[w][set] ← 1.
  - Zero-wait hit latency.
- CHECK, request, miss: victim v = invalid way if any (way 0 preferred), else lru[set].
  - dirty[v] → WRITEBACK; else → ALLOCATE.
  - mem_resp=0.
- WRITEBACK: l2_write=1, wb_way=v, l2_address={tag[v][set], set, 5'b0}. On l2_resp → ALLOCATE and dirty[v] ← 0.
- ALLOCATE: l2_read=1, l2_address={req tag, set, 5'b0}. On l2_resp:
  - data_we[v]=1, fill_sel=1;
  - tag[v] ← req tag, valid[v] ← 1, dirty[v] ← 0;
  - → CHECK.
  - The request then hits in CHECK, so a miss costs 1 extra cycle plus L2 latency.
- v is registered on the miss edge and held through WRITEBACK/ALLOCATE.
- mem_read & mem_write both high: treated as a write.
- CPU drops the request mid-miss: the fill still completes, and no mem_resp is issued for it.
- l2_read and l2_write are never high together; l2_resp in CHECK is ignored.

Optional Feature:
- Macro: L1_CACHE_CTRL_PERF_EN.
- Enabled:
  - adds outputs hit_count[15:0] and miss_count[15:0];
  - a hit increments on each mem_resp issued without a preceding miss for the same request; a miss increments on the CHECK→WRITEBACK/ALLOCATE edge;
  - counters wrap at 16'hFFFF → 0 and clear on reset.
- Disabled: ports and counters are absent, with no other behavioural change.

Decomposition:
- lc3b_types gains:
  - lc3b_l1_tag (8-bit at default);
  - lc3b_l1_set (SET_BITS);
  - enum l1_ctrl_state_t {CHECK, WRITEBACK, ALLOCATE};
  - constant L1_LINE_OFFSET_BITS = 5.
- One natural sub-module: l1_tag_array, which holds tag, valid and dirty per way, with async read and sync write. It is instantiated twice. LRU and FSM stay in l1_cache_control.

Test Plan:
- Cold read 0x1234 after reset:
  - CHECK miss → ALLOCATE with l2_address=0x1220;
  - l2_resp after 3 cycles → data_we=2'b01, fill_sel=1;
  - next cycle mem_resp=1, hit_way=0.
- Write 0x1236 after that fill:
  - same-cycle mem_resp=1, data_we=2'b01, fill_sel=0;
  - dirty[0][1]=1, lru[1]=1.
- Fill 0x1220 (way0) and 0x5620 (way1), dirty way0, then read 0x9A20:
  - WRITEBACK with l2_address=0x1220, wb_way=0;
  - then ALLOCATE with l2_address=0x9A20;
  - way0 refilled with dirty=0.
- Clean miss on set 1 with lru=1: no WRITEBACK; ALLOCATE writes way1 (data_we=2'b10).
- Assert reset during ALLOCATE: next cycle l2_read=0, state CHECK; a prior hit to 0x1234 now misses.
- With L1_CACHE_CTRL_PERF_EN: 3 hits + 2 misses → hit_count=3, miss_count=2; preload 16'hFFFF and one hit → 0.

Source files
------------

// File: rtl/l1_cache_control_pkg.sv
// Shared types and constants for the L1 cache controller slice.
// Line geometry: 16-bit byte address = tag | set | word[4:1] | byte[0].
package l1_cache_control_pkg;

    localparam int unsigned L1_ADDR_BITS        = 16;
    localparam int unsigned L1_LINE_OFFSET_BITS = 5;
    localparam int unsigned L1_SET_BITS         = 3;
    localparam int unsigned L1_TAG_BITS         = L1_ADDR_BITS - L1_LINE_OFFSET_BITS - L1_SET_BITS;

    typedef logic [L1_TAG_BITS-1:0] lc3b_l1_tag;
    typedef logic [L1_SET_BITS-1:0] lc3b_l1_set;

    typedef enum logic [1:0] {
        CHECK,
        WRITEBACK,
        ALLOCATE
    } l1_ctrl_state_t;

endpackage

// File: rtl/l1_cache_control_tag_array.sv
// Per-way tag/valid/dirty store: combinational read, synchronous write.
// A load installs a new tag as valid and clean; dirty can be written on its own.
module l1_tag_array
    import l1_cache_control_pkg::*;
#(
    parameter int unsigned SET_BITS = L1_SET_BITS,
    localparam int unsigned TAG_W   = L1_ADDR_BITS - L1_LINE_OFFSET_BITS - SET_BITS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [SET_BITS-1:0] set_idx,
    input  logic                load,
    input  logic [TAG_W-1:0]    load_tag,
    input  logic                dirty_we,
    input  logic                dirty_in,
    output logic [TAG_W-1:0]    tag_out,
    output logic                valid_out,
    output logic                dirty_out
);

    localparam int unsigned SETS = 1 << SET_BITS;

    logic [TAG_W-1:0] tag_q [SETS];
    logic [TAG_W-1:0] tag_d [SETS];
    logic [SETS-1:0]  valid_q, valid_d;
    logic [SETS-1:0]  dirty_q, dirty_d;

    assign tag_out   = tag_q[set_idx];
    assign valid_out = valid_q[set_idx];
    assign dirty_out = dirty_q[set_idx];

    // Next contents: install on load, explicit dirty update otherwise
    always_comb begin
        tag_d   = tag_q;
        valid_d = valid_q;
        dirty_d = dirty_q;
        if (load) begin
            tag_d[set_idx]   = load_tag;
            valid_d[set_idx] = 1'b1;
            dirty_d[set_idx] = 1'b0;
        end
        if (dirty_we) begin
            dirty_d[set_idx] = dirty_in;
        end
    end

    // Storage; tags need no reset because valid gates every use
    always_ff @(posedge clk) begin
        tag_q <= tag_d;
        if (reset) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

endmodule

// File: rtl/l1_cache_control.sv
// L1 cache control: hit/miss decision, dirty-victim writeback, line allocate.
// 2-way set-associative, write-back / write-allocate, 32-byte lines.
// Optional macro L1_CACHE_CTRL_PERF_EN adds hit_count / miss_count outputs.
module l1_cache_control
    import l1_cache_control_pkg::*;
#(
    parameter int unsigned SET_BITS = L1_SET_BITS,
    parameter int unsigned WAYS     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [15:0] mem_address,
    output logic        mem_resp,
    output logic        hit_way,
    output logic [1:0]  data_we,
    output logic        fill_sel,
    output logic        l2_read,
    output logic        l2_write,
    output logic [15:0] l2_address,
    output logic        wb_way,
    input  logic        l2_resp
`ifdef L1_CACHE_CTRL_PERF_EN
    ,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
`endif
);

    localparam int unsigned TAG_W = L1_ADDR_BITS - L1_LINE_OFFSET_BITS - SET_BITS;
    localparam int unsigned SETS  = 1 << SET_BITS;

    l1_ctrl_state_t    state_q, state_d;
    logic              victim_q, victim_d;
    logic [SET_BITS-1:0] miss_set_q, miss_set_d;
    logic [TAG_W-1:0]  miss_tag_q, miss_tag_d;
    logic [SETS-1:0]   lru_q, lru_d;
    logic              after_fill_q, after_fill_d;

    logic              req, is_write, hit, hw, victim_sel;
    logic [SET_BITS-1:0] cpu_set, arr_set;
    logic [TAG_W-1:0]  cpu_tag;
    logic [1:0]        hit_vec;
    logic [TAG_W-1:0]  way_tag [2];
    logic [1:0]        way_valid, way_dirty, way_load, way_dirty_we, way_dirty_in;
    logic [4:0]        unused_offset_bits;

    assign req      = mem_read | mem_write;
    assign is_write = mem_write;
    assign cpu_set  = mem_address[L1_LINE_OFFSET_BITS +: SET_BITS];
    assign cpu_tag  = mem_address[L1_ADDR_BITS-1 -: TAG_W];
    assign unused_offset_bits = mem_address[4:0];

    // During a miss the arrays are indexed by the registered miss set, so a
    // CPU that drops or changes its request cannot redirect the fill.
    assign arr_set = (state_q == CHECK) ? cpu_set : miss_set_q;

    l1_tag_array #(.SET_BITS(SET_BITS)) u_tag0 (
        .clk(clk), .reset(reset), .set_idx(arr_set),
        .load(way_load[0]), .load_tag(miss_tag_q),
        .dirty_we(way_dirty_we[0]), .dirty_in(way_dirty_in[0]),
        .tag_out(way_tag[0]), .valid_out(way_valid[0]), .dirty_out(way_dirty[0])
    );

    l1_tag_array #(.SET_BITS(SET_BITS)) u_tag1 (
        .clk(clk), .reset(reset), .set_idx(arr_set),
        .load(way_load[1]), .load_tag(miss_tag_q),
        .dirty_we(way_dirty_we[1]), .dirty_in(way_dirty_in[1]),
        .tag_out(way_tag[1]), .valid_out(way_valid[1]), .dirty_out(way_dirty[1])
    );

    assign hit_vec    = way_valid & {way_tag[1] == cpu_tag, way_tag[0] == cpu_tag};
    assign hit        = |hit_vec;
    assign hw         = ~hit_vec[0];
    assign victim_sel = ~way_valid[0] ? 1'b0 : (~way_valid[1] ? 1'b1 : lru_q[cpu_set]);

`ifdef L1_CACHE_CTRL_PERF_EN
    logic [15:0] hit_count_q, hit_count_d, miss_count_q, miss_count_d;
    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

    // State register plus LRU, victim and miss-request capture
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= CHECK;
            victim_q     <= 1'b0;
            miss_set_q   <= '0;
            miss_tag_q   <= '0;
            lru_q        <= '0;
            after_fill_q <= 1'b0;
`ifdef L1_CACHE_CTRL_PERF_EN
            hit_count_q  <= '0;
            miss_count_q <= '0;
`endif
        end else begin
            state_q      <= state_d;
            victim_q     <= victim_d;
            miss_set_q   <= miss_set_d;
            miss_tag_q   <= miss_tag_d;
            lru_q        <= lru_d;
            after_fill_q <= after_fill_d;
`ifdef L1_CACHE_CTRL_PERF_EN
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
`endif
        end
    end

    // Only two ways are implemented
    always_ff @(posedge clk) begin
        assert (WAYS == 2) else $error("l1_cache_control supports WAYS == 2 only");
    end

    // Next state, tag/status updates and LRU update
    always_comb begin
        state_d      = state_q;
        victim_d     = victim_q;
        miss_set_d   = miss_set_q;
        miss_tag_d   = miss_tag_q;
        lru_d        = lru_q;
        after_fill_d = 1'b0;
        way_load     = '0;
        way_dirty_we = '0;
        way_dirty_in = '0;
`ifdef L1_CACHE_CTRL_PERF_EN
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
`endif
        case (state_q)
            CHECK: begin
                if (req && hit) begin
                    lru_d[cpu_set] = ~hw;
                    if (is_write) begin
                        way_dirty_we[hw] = 1'b1;
                        way_dirty_in[hw] = 1'b1;
                    end
`ifdef L1_CACHE_CTRL_PERF_EN
                    // The first hit after a fill completes an already-counted miss
                    if (!after_fill_q) hit_count_d = hit_count_q + 16'd1;
`endif
                end else if (req) begin
                    victim_d   = victim_sel;
                    miss_set_d = cpu_set;
                    miss_tag_d = cpu_tag;
                    state_d    = way_dirty[victim_sel] ? WRITEBACK : ALLOCATE;
`ifdef L1_CACHE_CTRL_PERF_EN
                    miss_count_d = miss_count_q + 16'd1;
`endif
                end
            end
            WRITEBACK: begin
                if (l2_resp) begin
                    way_dirty_we[victim_q] = 1'b1;
                    state_d                = ALLOCATE;
                end
            end
            ALLOCATE: begin
                if (l2_resp) begin
                    way_load[victim_q] = 1'b1;
                    after_fill_d       = 1'b1;
                    state_d            = CHECK;
                end
            end
            default: state_d = CHECK;
        endcase
    end

    // Outputs to CPU, data arrays and L2
    always_comb begin
        mem_resp   = 1'b0;
        hit_way    = 1'b0;
        data_we    = '0;
        fill_sel   = 1'b0;
        l2_read    = 1'b0;
        l2_write   = 1'b0;
        l2_address = '0;
        wb_way     = 1'b0;
        case (state_q)
            CHECK: begin
                if (req && hit) begin
                    mem_resp = 1'b1;
                    hit_way  = hw;
                    if (is_write) data_we[hw] = 1'b1;
                end
            end
            WRITEBACK: begin
                l2_write   = 1'b1;
                wb_way     = victim_q;
                l2_address = {way_tag[victim_q], miss_set_q, 5'b0};
            end
            ALLOCATE: begin
                l2_read    = 1'b1;
                l2_address = {miss_tag_q, miss_set_q, 5'b0};
                if (l2_resp) begin
                    data_we[victim_q] = 1'b1;
                    fill_sel          = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_l1_cache_control.sv
// Randomized self-checking bench for l1_cache_control against a
// transaction-level cache model (tag/valid/dirty/LRU arrays).
module tb_l1_cache_control;

    logic        clk, reset;
    logic        mem_read, mem_write;
    logic [15:0] mem_address;
    logic        mem_resp, hit_way, fill_sel, l2_read, l2_write, wb_way, l2_resp;
    logic [1:0]  data_we;
    logic [15:0] l2_address;
`ifdef L1_CACHE_CTRL_PERF_EN
    logic [15:0] hit_count, miss_count;
`endif

    l1_cache_control dut (
        .clk(clk), .reset(reset),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_resp(mem_resp), .hit_way(hit_way), .data_we(data_we), .fill_sel(fill_sel),
        .l2_read(l2_read), .l2_write(l2_write), .l2_address(l2_address),
        .wb_way(wb_way), .l2_resp(l2_resp)
`ifdef L1_CACHE_CTRL_PERF_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model state
    bit       m_valid [2][8];
    bit       m_dirty [2][8];
    bit [7:0] m_tag   [2][8];
    bit       m_lru   [8];
    int       m_hits, m_misses;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int w = 0; w < 2; w++)
            for (int s = 0; s < 8; s++) begin
                m_valid[w][s] = 1'b0;
                m_dirty[w][s] = 1'b0;
                m_tag[w][s]   = 8'h00;
            end
        for (int s = 0; s < 8; s++) m_lru[s] = 1'b0;
        m_hits = 0;
        m_misses = 0;
    endtask

    task automatic check_idle(input string tag);
        check_eq(tag, 32'({mem_resp, hit_way, data_we, fill_sel, l2_read, l2_write, wb_way, l2_address}), 32'd0);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One CPU access, acting as L2 with the given latencies (cycles before l2_resp).
    task automatic access(input logic [15:0] addr, input bit wr, input bit rd,
                          input int lat_wb, input int lat_al, input bit drop);
        bit [2:0] s;
        bit [7:0] t;
        bit       hit;
        int       hw, v;
        s = addr[7:5];
        t = addr[15:8];
        mem_address = addr;
        mem_write   = wr;
        mem_read    = rd;
        #1;
        hit = 1'b0;
        hw  = 0;
        for (int w = 0; w < 2; w++)
            if (!hit && m_valid[w][s] && m_tag[w][s] == t) begin
                hit = 1'b1;
                hw  = w;
            end
        if (hit) begin
            check_eq("hit_resp", 32'(mem_resp), 32'd1);
            check_eq("hit_way", 32'(hit_way), 32'(hw));
            check_eq("hit_we", 32'(data_we), wr ? (32'd1 << hw) : 32'd0);
            check_eq("hit_fill_sel", 32'(fill_sel), 32'd0);
            check_eq("hit_l2_idle", 32'({l2_read, l2_write}), 32'd0);
            m_lru[s] = (hw == 0);
            if (wr) m_dirty[hw][s] = 1'b1;
            m_hits++;
            next_cycle();
        end else begin
            check_eq("miss_resp", 32'(mem_resp), 32'd0);
            check_eq("miss_we", 32'(data_we), 32'd0);
            v = !m_valid[0][s] ? 0 : (!m_valid[1][s] ? 1 : int'(m_lru[s]));
            m_misses++;
            next_cycle();
            if (m_dirty[v][s]) begin
                for (int i = 0; i <= lat_wb; i++) begin
                    if (i == lat_wb) l2_resp = 1'b1;
                    #1;
                    check_eq("wb_req", 32'({l2_write, l2_read}), 32'd2);
                    check_eq("wb_addr", 32'(l2_address), 32'({m_tag[v][s], s, 5'b0}));
                    check_eq("wb_way", 32'(wb_way), 32'(v));
                    check_eq("wb_quiet", 32'({mem_resp, data_we}), 32'd0);
                    next_cycle();
                    l2_resp = 1'b0;
                end
                m_dirty[v][s] = 1'b0;
            end
            if (drop) begin
                mem_read    = 1'b0;
                mem_write   = 1'b0;
                mem_address = 16'($urandom);
            end
            for (int i = 0; i <= lat_al; i++) begin
                if (i == lat_al) l2_resp = 1'b1;
                #1;
                check_eq("al_req", 32'({l2_write, l2_read}), 32'd1);
                check_eq("al_addr", 32'(l2_address), 32'({t, s, 5'b0}));
                check_eq("al_we", 32'(data_we), (i == lat_al) ? (32'd1 << v) : 32'd0);
                check_eq("al_fill_sel", 32'(fill_sel), (i == lat_al) ? 32'd1 : 32'd0);
                check_eq("al_resp", 32'(mem_resp), 32'd0);
                next_cycle();
                l2_resp = 1'b0;
            end
            m_valid[v][s] = 1'b1;
            m_tag[v][s]   = t;
            m_dirty[v][s] = 1'b0;
            #1;
            if (drop) begin
                check_idle("drop_no_resp");
            end else begin
                check_eq("refill_resp", 32'(mem_resp), 32'd1);
                check_eq("refill_way", 32'(hit_way), 32'(v));
                check_eq("refill_we", 32'(data_we), wr ? (32'd1 << v) : 32'd0);
                check_eq("refill_l2", 32'({l2_read, l2_write}), 32'd0);
                m_lru[s] = (v == 0);
                if (wr) m_dirty[v][s] = 1'b1;
            end
            next_cycle();
        end
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    // No request; a stray l2_resp must be ignored
    task automatic idle_cycle(input bit stray);
        mem_read  = 1'b0;
        mem_write = 1'b0;
        l2_resp   = stray;
        #1;
        check_idle("idle");
        next_cycle();
        l2_resp = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        l2_resp   = 1'b0;
        next_cycle();
        #1;
        check_idle("reset_outputs");
        reset = 1'b0;
        model_reset();
        next_cycle();
    endtask

    initial begin
        bit [7:0] tags [4];
        tags = '{8'h12, 8'h56, 8'h9A, 8'hBC};
        reset = 1'b1;
        mem_read = 1'b0;
        mem_write = 1'b0;
        mem_address = 16'h0000;
        l2_resp = 1'b0;
        model_reset();
        @(negedge clk);
        apply_reset();

        // Directed sequence on set 1
        access(16'h1234, 1'b0, 1'b1, 0, 3, 1'b0);   // cold miss -> way0
        access(16'h1236, 1'b1, 1'b0, 0, 0, 1'b0);   // write hit, dirty way0, lru=1
        access(16'h5620, 1'b0, 1'b1, 0, 1, 1'b0);   // fill way1, lru=0
        access(16'h9A20, 1'b0, 1'b1, 2, 2, 1'b0);   // writeback 0x1220, refill way0
        access(16'hBC20, 1'b0, 1'b1, 0, 1, 1'b0);   // clean miss, lru=1 -> way1
        access(16'hBC22, 1'b1, 1'b1, 0, 0, 1'b0);   // read+write treated as write
        idle_cycle(1'b1);

        // Reset while allocating abandons the fill
        apply_reset();
        access(16'h1234, 1'b0, 1'b1, 0, 1, 1'b0);
        mem_address = 16'h7734;
        mem_read    = 1'b1;
        next_cycle();
        #1;
        check_eq("pre_reset_l2_read", 32'(l2_read), 32'd1);
        reset = 1'b1;
        next_cycle();
        mem_read = 1'b0;
        #1;
        check_idle("reset_mid_alloc");
        reset = 1'b0;
        model_reset();
        next_cycle();
        access(16'h1234, 1'b0, 1'b1, 0, 0, 1'b0);   // must miss again

        // Randomized traffic over few tags to force conflicts and evictions
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                idle_cycle(1'($urandom_range(0, 1)));
            end else begin
                logic [15:0] a;
                bit wr, rd;
                int sel;
                a = 16'($urandom);
                a[15:8] = tags[$urandom_range(0, 3)];
                sel = $urandom_range(0, 2);
                wr = (sel != 0);
                rd = (sel != 1);
                access(a, wr, rd, $urandom_range(0, 3), $urandom_range(0, 3),
                       $urandom_range(0, 7) == 0);
            end
        end

`ifdef L1_CACHE_CTRL_PERF_EN
        check_eq("hit_count", 32'(hit_count), 32'(m_hits[15:0]));
        check_eq("miss_count", 32'(miss_count), 32'(m_misses[15:0]));
        apply_reset();
        check_eq("hit_count_reset", 32'(hit_count), 32'd0);
        access(16'h1234, 1'b0, 1'b1, 0, 0, 1'b0);
        access(16'h5634, 1'b0, 1'b1, 0, 0, 1'b0);
        access(16'h1234, 1'b0, 1'b1, 0, 0, 1'b0);
        access(16'h5634, 1'b1, 1'b0, 0, 0, 1'b0);
        access(16'h1236, 1'b0, 1'b1, 0, 0, 1'b0);
        check_eq("hit_count_3", 32'(hit_count), 32'd3);
        check_eq("miss_count_2", 32'(miss_count), 32'd2);
        // Hold a hitting read: one hit per cycle up to the wrap point
        mem_address = 16'h1234;
        mem_read    = 1'b1;
        for (int i = 3; i < 65535; i++) begin
            @(posedge clk);
        end
        @(negedge clk);
        mem_read = 1'b0;
        #1;
        check_eq("hit_count_max", 32'(hit_count), 32'hFFFF);
        access(16'h1234, 1'b0, 1'b1, 0, 0, 1'b0);
        check_eq("hit_count_wrap", 32'(hit_count), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
